alu_arbiter: RTL and testbench

//  Shares one combinational alu #(N) between two requesters. Each requester has a valid/ready

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational alu between two requesters.
//
// A round-robin FSM picks one command, registers its op and operands onto the
// alu inputs, captures alu_out one cycle later and returns it to the winner
// on its response channel. Illegal ops (op >= NUM_OPS) skip the alu and are
// answered directly with result 0 and err set.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqX_valid/ready           command handshake for requester X (0/1)
//   reqX_op/in1/in0            command op code and operands
//   rspX_valid/ready           response handshake for requester X
//   rspX_out/err               result and illegal-op flag (from result regs)
//   alu_op/in1/in0             registered inputs to the external alu
//   alu_out                    combinational result from the external alu
module alu_arbiter #(
  parameter int N       = 4,
  parameter int NUM_OPS = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N-1:0] req0_in1,
  input  logic [N-1:0] req0_in0,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_out,
  output logic         rsp0_err,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N-1:0] req1_in1,
  input  logic [N-1:0] req1_in0,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_out,
  output logic         rsp1_err,
  output logic [3:0]   alu_op,
  output logic [N-1:0] alu_in1,
  output logic [N-1:0] alu_in0,
  input  logic [N-1:0] alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_reg, state_next;
  logic         last_grant_reg, last_grant_next;
  logic         grant_reg, grant_next;
  logic [3:0]   alu_op_reg, alu_op_next;
  logic [N-1:0] alu_in1_reg, alu_in1_next;
  logic [N-1:0] alu_in0_reg, alu_in0_next;
  logic [N-1:0] result_reg, result_next;
  logic         err_reg, err_next;

  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic         grant_sel;
  logic [3:0]   sel_op;
  logic [N-1:0] sel_in1, sel_in0;
  logic         sel_legal;
  logic         cmd_accept;
  logic         rsp_done;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Single requester wins outright; on a tie the one not served last wins.
  assign grant_sel = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (grant_sel == 1'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
    end
  endgenerate

  assign sel_op     = grant_sel ? req1_op  : req0_op;
  assign sel_in1    = grant_sel ? req1_in1 : req0_in1;
  assign sel_in0    = grant_sel ? req1_in0 : req0_in0;
  assign sel_legal  = 32'(sel_op) < 32'(NUM_OPS);
  assign cmd_accept = |req_ready;
  assign rsp_done   = (state_reg == RESP) && rsp_ready[grant_reg];

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    alu_op_next     = alu_op_reg;
    alu_in1_next    = alu_in1_reg;
    alu_in0_next    = alu_in0_reg;
    result_next     = result_reg;
    err_next        = err_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_accept) begin
          grant_next = grant_sel;
          if (sel_legal) begin
            alu_op_next  = sel_op;
            alu_in1_next = sel_in1;
            alu_in0_next = sel_in0;
            state_next   = EXEC;
          end else begin
            // Illegal op never reaches the alu; alu_* keep their old values.
            result_next = '0;
            err_next    = 1'b1;
            state_next  = RESP;
          end
        end
      end
      EXEC: begin
        // alu inputs have been stable for this whole cycle.
        result_next = alu_out;
        err_next    = 1'b0;
        state_next  = RESP;
      end
      RESP: begin
        if (rsp_done) begin
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      alu_op_reg     <= '0;
      alu_in1_reg    <= '0;
      alu_in0_reg    <= '0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      alu_op_reg     <= alu_op_next;
      alu_in1_reg    <= alu_in1_next;
      alu_in0_reg    <= alu_in0_next;
      result_reg     <= result_next;
      err_reg        <= err_next;
    end
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_out   = result_reg;
  assign rsp1_out   = result_reg;
  assign rsp0_err   = err_reg;
  assign rsp1_err   = err_reg;
  assign alu_op     = alu_op_reg;
  assign alu_in1    = alu_in1_reg;
  assign alu_in0    = alu_in0_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter with an
// XOR alu stub. Expected grants, results and alu port values come from a
// small transaction-level model (round-robin pointer, legal-op rule, XOR).
module tb_alu_arbiter;
  logic clk;
  logic reset;
  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][3:0] req_op, req_in1, req_in0, rsp_out;
  logic [1:0]      rsp_err;
  logic [3:0]      alu_op, alu_in1, alu_in0, alu_out;

  int checks;
  int failures;
  logic       model_last;
  logic [3:0] model_alu_op, model_alu_in1, model_alu_in0;

  assign alu_out = alu_in1 ^ alu_in0;

  alu_arbiter #(.N(4), .NUM_OPS(6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]),
    .req0_in1(req_in1[0]), .req0_in0(req_in0[0]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_out(rsp_out[0]), .rsp0_err(rsp_err[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]),
    .req1_in1(req_in1[1]), .req1_in0(req_in0[1]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_out(rsp_out[1]), .rsp1_err(rsp_err[1]),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in0(alu_in0), .alu_out(alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction. Called at a falling edge; returns just after a
  // falling edge with the arbiter back in IDLE. The losing requester keeps
  // its valid asserted throughout.
  task automatic run_cmd(input logic [1:0] v, input int stall);
    int         w;
    int         cyc;
    logic       legal;
    logic [3:0] exp_out;
    w       = (v == 2'b11) ? (model_last ? 0 : 1) : (v[1] ? 1 : 0);
    legal   = req_op[w] < 4'd6;
    exp_out = legal ? (req_in1[w] ^ req_in0[w]) : 4'h0;
    req_valid = v;
    rsp_ready = 2'b00;
    #1;
    cyc = 0;
    while (req_ready !== (2'b01 << w) && cyc < 8) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("grant", 32'(req_ready), 32'(2'b01 << w));
    chk("grant_latency", cyc, 0);
    @(negedge clk);
    req_valid[w] = 1'b0;
    #1;
    if (legal) begin
      model_alu_op  = req_op[w];
      model_alu_in1 = req_in1[w];
      model_alu_in0 = req_in0[w];
      chk("exec_rsp_valid", 32'(rsp_valid), 0);
      chk("exec_req_ready", 32'(req_ready), 0);
      chk("alu_in1", 32'(alu_in1), 32'(model_alu_in1));
      chk("alu_in0", 32'(alu_in0), 32'(model_alu_in0));
      @(negedge clk); #1;
    end
    chk("alu_op", 32'(alu_op), 32'(model_alu_op));
    chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << w));
    chk("rsp_out", 32'(rsp_out[w]), 32'(exp_out));
    chk("rsp_err", 32'(rsp_err[w]), 32'(!legal));
    chk("resp_req_ready", 32'(req_ready), 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'(2'b01 << w));
      chk("stall_rsp_out", 32'(rsp_out[w]), 32'(exp_out));
      chk("stall_req_ready", 32'(req_ready), 0);
    end
    rsp_ready[w] = 1'b1;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("rsp_done", 32'(rsp_valid), 0);
    model_last = w[0];
    $display("txn req%0d op=%0h in1=%0h in0=%0h out=%0h err=%0b stall=%0d",
             w, req_op[w], req_in1[w], req_in0[w], rsp_out[w], rsp_err[w], stall);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    req_valid = '0; rsp_ready = '0;
    req_op = '0; req_in1 = '0; req_in0 = '0;
    model_last = 1'b1;
    model_alu_op = '0; model_alu_in1 = '0; model_alu_in0 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_alu_op", 32'(alu_op), 0);
    chk("reset_alu_in1", 32'(alu_in1), 0);
    @(negedge clk);
    reset = 1'b0;

    // Tie from reset: req0 first, then alternation over 4 commands.
    req_op[0] = 4'h1; req_in1[0] = 4'h3; req_in0[0] = 4'h5;
    req_op[1] = 4'h2; req_in1[1] = 4'h9; req_in0[1] = 4'h6;
    repeat (4) run_cmd(2'b11, 0);

    // req0 alone: a ^ d = 7.
    req_op[0] = 4'h0; req_in1[0] = 4'ha; req_in0[0] = 4'hd;
    run_cmd(2'b01, 0);

    // Illegal op on req1: immediate response, err, alu_op unchanged.
    req_op[1] = 4'h6; req_in1[1] = 4'hf; req_in0[1] = 4'h1;
    run_cmd(2'b10, 0);

    // Backpressure on req0 with req1 waiting, then req1 served at once.
    req_op[0] = 4'h3; req_in1[0] = 4'ha; req_in0[0] = 4'hd;
    req_op[1] = 4'h4; req_in1[1] = 4'h2; req_in0[1] = 4'h8;
    run_cmd(2'b11, 5);
    run_cmd(2'b10, 0);

    // Op sweep on req0.
    for (int op = 0; op < 6; op++) begin
      req_op[0] = 4'(op); req_in1[0] = 4'ha; req_in0[0] = 4'hd;
      run_cmd(2'b01, 0);
    end

    // Reset during EXEC drops the transaction.
    req_op[0] = 4'h2; req_in1[0] = 4'h7; req_in0[0] = 4'h1;
    req_valid = 2'b01;
    #1;
    chk("pre_reset_grant", 32'(req_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_last = 1'b1;
    model_alu_op = '0; model_alu_in1 = '0; model_alu_in0 = '0;
    chk("rst_exec_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_exec_req_ready", 32'(req_ready), 0);
    chk("rst_exec_alu_op", 32'(alu_op), 0);
    @(negedge clk); #1;
    chk("rst_exec_no_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    req_op[0] = 4'h5; req_in1[0] = 4'hc; req_in0[0] = 4'h3;
    req_op[1] = 4'h1; req_in1[1] = 4'h4; req_in0[1] = 4'h4;
    run_cmd(2'b11, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < 2; r++) begin
        req_op[r]  = 4'($urandom_range(0, 7));
        req_in1[r] = 4'($urandom_range(0, 15));
        req_in0[r] = 4'($urandom_range(0, 15));
      end
      run_cmd(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end
    req_valid = 2'b00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
